// File: rtl/sobel_pkg.sv
// sobel_pkg: shared gradient width, output mode constants and counter-width helper for the Sobel pipe
package sobel_pkg;
  localparam int MODE_MAG = 0;
  localparam int MODE_THR = 1;
  // GRAD_W = PIX_W + 3 holds a signed Sobel gradient or the unsigned |Gx|+|Gy| sum
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: two IMG_W-deep line stores, read and rewritten at one column address per enable
// ports: clk; en_i shifts column addr_i; din_i enters as newest line; up_o/up2_o are lines r-1/r-2 (registered)
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int AW    = cnt_w(IMG_W)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] up_o,
  output logic [PIX_W-1:0] up2_o
);
  logic [PIX_W-1:0] mem0_q [IMG_W];
  logic [PIX_W-1:0] mem1_q [IMG_W];
  always_ff @(posedge clk) begin
    if (en_i) begin
      up_o           <= mem0_q[addr_i];
      up2_o          <= mem1_q[addr_i];
      mem0_q[addr_i] <= din_i;
      mem1_q[addr_i] <= mem0_q[addr_i];
    end
  end
endmodule

// File: rtl/sobel_stream_pipe.sv
// sobel_stream_pipe: streaming 3x3 Sobel edge detector emitting the interior (IMG_W-2)x(IMG_H-2) window
// ports: clk, rst (async, active-high); s_* input stream with s_sof and cfg_thresh (sampled on SOF);
//        m_* output stream with m_sof/m_eol; frame_err pulses on early SOF or line overrun
module sobel_stream_pipe
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int MODE  = MODE_MAG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic [PIX_W-1:0] cfg_thresh,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             frame_err
);
  localparam int GW = grad_w(PIX_W);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_H);
  logic rdy_q, active_q, en, fire, ok, ovr, early;
  logic [CW-1:0] col_q, col_d, c;
  logic [RW-1:0] row_q, row_d, r;
  logic [PIX_W-1:0] thresh_q, px_q, up, up2, res;
  logic [PIX_W-1:0] w_q [3][3];
  logic signed [GW-1:0] p [3][3];
  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic [GW-1:0] ax, ay, mag;
  logic a_vld_q, a_out_q, a_sof_q, a_eol_q, b_vld_q, b_sof_q, b_eol_q, g_vld_q, g_sof_q, g_eol_q;
  assign en      = !m_valid || m_ready;
  assign s_ready = rdy_q && en;
  assign fire    = s_valid && s_ready;
  assign c       = s_sof ? '0 : col_q;
  assign r       = s_sof ? '0 : row_q;
  // beats are kept only inside a live frame; the first beat past IMG_H lines ends the frame
  assign ok      = fire && (s_sof || (active_q && row_q != ROW_END));
  assign ovr     = fire && !s_sof && active_q && row_q == ROW_END;
  assign early   = fire && s_sof && active_q && row_q != ROW_END && (row_q != '0 || col_q != '0);
  assign col_d   = (c == COL_LAST) ? '0 : c + 1'b1;
  assign row_d   = (c == COL_LAST) ? r + 1'b1 : r;
  sobel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W), .AW(CW)) u_lb (
    .clk   (clk),
    .en_i  (ok),
    .addr_i(c),
    .din_i (s_data),
    .up_o  (up),
    .up2_o (up2)
  );
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = GW'(w_q[i][j]);
    gx_d = p[0][2] + p[1][2] + p[1][2] + p[2][2] - p[0][0] - p[1][0] - p[1][0] - p[2][0];
    gy_d = p[2][0] + p[2][1] + p[2][1] + p[2][2] - p[0][0] - p[0][1] - p[0][1] - p[0][2];
    ax   = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    ay   = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag  = ax + ay;
    res  = (MODE == MODE_THR) ? ((mag >= GW'(thresh_q)) ? '1 : '0)
                              : ((mag > GW'({PIX_W{1'b1}})) ? '1 : mag[PIX_W-1:0]);
  end
  // window rows: 0 = line r-2, 1 = line r-1, 2 = current line; column 2 is newest
  always_ff @(posedge clk) begin
    if (en) begin
      px_q <= s_data;
      if (a_vld_q) begin
        for (int i = 0; i < 3; i++) begin
          w_q[i][0] <= w_q[i][1];
          w_q[i][1] <= w_q[i][2];
        end
        w_q[0][2] <= up2;
        w_q[1][2] <= up;
        w_q[2][2] <= px_q;
      end
      gx_q <= gx_d;
      gy_q <= gy_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0; active_q <= 1'b0; col_q <= '0; row_q <= '0; thresh_q <= '0; frame_err <= 1'b0;
      a_vld_q <= 1'b0; a_out_q <= 1'b0; a_sof_q <= 1'b0; a_eol_q <= 1'b0;
      b_vld_q <= 1'b0; b_sof_q <= 1'b0; b_eol_q <= 1'b0;
      g_vld_q <= 1'b0; g_sof_q <= 1'b0; g_eol_q <= 1'b0;
      m_valid <= 1'b0; m_data <= '0; m_sof <= 1'b0; m_eol <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      frame_err <= early || ovr;
      if (ok) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (fire && s_sof) begin
        active_q <= 1'b1;
        thresh_q <= cfg_thresh;
      end else if (ovr) active_q <= 1'b0;
      if (en) begin
        a_vld_q <= ok;
        a_out_q <= ok && r >= RW'(2) && c >= CW'(2);
        a_sof_q <= ok && r == RW'(2) && c == CW'(2);
        a_eol_q <= ok && r >= RW'(2) && c == COL_LAST;
        b_vld_q <= a_out_q; b_sof_q <= a_sof_q; b_eol_q <= a_eol_q;
        g_vld_q <= b_vld_q; g_sof_q <= b_sof_q; g_eol_q <= b_eol_q;
        m_valid <= g_vld_q; m_sof   <= g_sof_q; m_eol   <= g_eol_q;
        m_data  <= res;
      end
    end
  end
endmodule
